// File: rtl/dsp_mac_pkg.sv
// Shared types and OPMODE encodings for the DSP48A1 multiply-accumulate sequencer.
package dsp_mac_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int DATA_W = 18;
  localparam int ACC_W  = 48;
  localparam int OPM_W  = 8;

  // X=M,Z=0 / X=M,Z=P / X=0,Z=P; carry-in and post-adder subtract stay 0
  localparam logic [OPM_W-1:0] OPM_CLEAR = 8'h01;
  localparam logic [OPM_W-1:0] OPM_ACC   = 8'h09;
  localparam logic [OPM_W-1:0] OPM_HOLD  = 8'h08;

  localparam int OPM_PREADD_BIT = 4;

  function automatic logic [OPM_W-1:0] opm_sel(input logic hs, input logic first);
    if (!hs)       return OPM_HOLD;
    else if (first) return OPM_CLEAR;
    else           return OPM_ACC;
  endfunction

endpackage

// File: rtl/dsp_delay_line.sv
// Fixed-depth shift register with an async reset value; a depth of 0 is a wire.
module dsp_delay_line #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_sr
      logic [DEPTH-1:0][WIDTH-1:0] sr;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sr <= {DEPTH{RST_VAL}};
        end else begin
          sr[0] <= din;
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end

      assign dout = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/dsp_mac_ctrl.sv
// Sequencer driving one DSP48A1 slice as a MAC: operand issue, OPMODE alignment, result capture.
// Optional feature macro DSP_MAC_PREADD_EN adds s_d through the slice pre-adder (sum of a*(d+b)).
module dsp_mac_ctrl
  import dsp_mac_pkg::*;
#(
  parameter int LEN_W   = 13,
  parameter int LAT     = 4,
  parameter int OPM_DLY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_a,
  input  logic [DATA_W-1:0] s_b,
`ifdef DSP_MAC_PREADD_EN
  input  logic [DATA_W-1:0] s_d,
`endif
  output logic              r_valid,
  input  logic              r_ready,
  output logic [ACC_W-1:0]  r_data,
  output logic              busy,
  output logic [DATA_W-1:0] dsp_A,
  output logic [DATA_W-1:0] dsp_B,
  output logic [DATA_W-1:0] dsp_D,
  output logic [OPM_W-1:0]  dsp_OPMODE,
  input  logic [ACC_W-1:0]  dsp_P
);

  localparam int DRN_W = $clog2(LAT + 1) + 1;

  state_t            state, state_nx;
  logic [LEN_W-1:0]  len_q, smp_cnt;
  logic [DRN_W-1:0]  drn_cnt;
  logic              zero_len;
  logic              hs, last_smp, drn_done;
  logic [OPM_W-1:0]  opm_q, opm_dly;

  assign hs       = (state == RUN) && s_valid;
  assign last_smp = hs && (smp_cnt == len_q - LEN_W'(1));
  assign drn_done = (state == DRAIN) && (zero_len || drn_cnt == DRN_W'(LAT));

  assign s_ready  = (state == RUN);
  assign r_valid  = (state == DONE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // A zero-length command passes through one DRAIN cycle without touching the
  // slice, so its result is presented one edge after the command.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)    state_nx = (len == '0) ? DRAIN : RUN;
      RUN:     if (last_smp) state_nx = DRAIN;
      DRAIN:   if (drn_done) state_nx = DONE;
      DONE:    if (r_ready)  state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      smp_cnt  <= '0;
      zero_len <= 1'b0;
      drn_cnt  <= '0;
      r_data   <= '0;
    end else begin
      if (state == IDLE && start) begin
        len_q    <= len;
        smp_cnt  <= '0;
        zero_len <= (len == '0);
      end else if (hs) begin
        smp_cnt  <= smp_cnt + LEN_W'(1);
      end
      drn_cnt <= (state == DRAIN) ? drn_cnt + DRN_W'(1) : '0;
      if (drn_done) r_data <= zero_len ? '0 : dsp_P;
    end
  end

  // Operand registers; anything other than a handshake issues a zero bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsp_A <= '0;
      dsp_B <= '0;
      dsp_D <= '0;
      opm_q <= OPM_HOLD;
    end else begin
      dsp_A <= hs ? s_a : '0;
      dsp_B <= hs ? s_b : '0;
`ifdef DSP_MAC_PREADD_EN
      dsp_D <= hs ? s_d : '0;
`else
      dsp_D <= '0;
`endif
      opm_q <= opm_sel(hs, smp_cnt == '0);
    end
  end

  // Delays OPMODE so the slice's OPMODE register lines up with its M register.
  dsp_delay_line #(
    .WIDTH   (OPM_W),
    .DEPTH   (OPM_DLY),
    .RST_VAL (OPM_HOLD)
  ) u_opm_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (opm_q),
    .dout (opm_dly)
  );

`ifdef DSP_MAC_PREADD_EN
  // Pre-adder select is consumed a cycle ahead of the other bits, so it is held
  // for the whole command instead of travelling through the delay line.
  logic preadd_on;
  assign preadd_on  = (state == RUN) || (state == DRAIN);
  assign dsp_OPMODE = opm_dly | (OPM_W'(preadd_on) << OPM_PREADD_BIT);
`else
  assign dsp_OPMODE = opm_dly;
`endif

endmodule
